// File: rtl/mux41_scan_ctrl.sv
// Round-robin scan controller for a 4:1 mux stage. It steps the select lines through the
// enabled channels, holds each one for a dwell time, samples the mux output and reports sweeps.
module mux41_scan_ctrl #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               continuous_i,
    input  logic               stop_i,
    input  logic [3:0]         ch_mask_i,
    input  logic [DWELL_W-1:0] dwell_i,
    input  logic               y_in_i,
    output logic               s0_o,
    output logic               s1_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [3:0]         sample_o,
    output logic               sample_valid_o
);

    typedef enum logic [0:0] {StIdle, StDwell} state_e;

    state_e             state_q, state_d;
    logic [1:0]         ch_q, ch_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [3:0]         mask_q, mask_d;
    logic               cont_q, cont_d;
    logic               stop_q, stop_d;
    logic               done_q, done_d;
    logic [3:0]         sample_q, sample_d;
    logic               valid_q, valid_d;

    logic [DWELL_W-1:0] dwell_eff;
    logic               last_cycle;
    logic [2:0]         next_hit;

    function automatic logic [1:0] lowest_ch(input logic [3:0] mask);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // {found, index} of the lowest enabled channel strictly above ch.
    function automatic logic [2:0] next_ch(input logic [1:0] ch, input logic [3:0] mask);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (i > int'(ch))) res = {1'b1, 2'(i)};
        end
        return res;
    endfunction

    assign dwell_eff  = (dwell_i == '0) ? DWELL_W'(1) : dwell_i;
    assign last_cycle = (cnt_q == dwell_q - DWELL_W'(1));
    assign next_hit   = next_ch(ch_q, mask_q);

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        dwell_d  = dwell_q;
        mask_d   = mask_q;
        cont_d   = cont_q;
        stop_d   = stop_q;
        done_d   = 1'b0;
        sample_d = sample_q;
        valid_d  = valid_q;

        unique case (state_q)
            StIdle: begin
                ch_d   = 2'd0;
                cnt_d  = '0;
                stop_d = 1'b0;
                if (start_i && (ch_mask_i != 4'd0)) begin
                    mask_d  = ch_mask_i;
                    dwell_d = dwell_eff;
                    cont_d  = continuous_i;
                    ch_d    = lowest_ch(ch_mask_i);
                    state_d = StDwell;
                end
            end
            StDwell: begin
                if (stop_i) stop_d = 1'b1;
                if (last_cycle) begin
                    sample_d[ch_q] = y_in_i;
                    cnt_d          = '0;
                    if (next_hit[2]) begin
                        ch_d = next_hit[1:0];
                    end else begin
                        done_d  = 1'b1;
                        valid_d = 1'b1;
                        if (!cont_q || stop_q || stop_i) begin
                            state_d = StIdle;
                            ch_d    = 2'd0;
                            stop_d  = 1'b0;
                        end else begin
                            mask_d  = ch_mask_i;
                            dwell_d = dwell_eff;
                            // An empty mask at the wrap point ends scanning like a stop.
                            if (ch_mask_i == 4'd0) begin
                                state_d = StIdle;
                                ch_d    = 2'd0;
                                stop_d  = 1'b0;
                            end else begin
                                ch_d = lowest_ch(ch_mask_i);
                            end
                        end
                    end
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                ch_d    = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            ch_q     <= 2'd0;
            cnt_q    <= '0;
            dwell_q  <= '0;
            mask_q   <= 4'd0;
            cont_q   <= 1'b0;
            stop_q   <= 1'b0;
            done_q   <= 1'b0;
            sample_q <= 4'd0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            dwell_q  <= dwell_d;
            mask_q   <= mask_d;
            cont_q   <= cont_d;
            stop_q   <= stop_d;
            done_q   <= done_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
        end
    end

    assign s0_o           = ch_q[0];
    assign s1_o           = ch_q[1];
    assign busy_o         = (state_q == StDwell);
    assign done_o         = done_q;
    assign sample_o       = sample_q;
    assign sample_valid_o = valid_q;

endmodule

// File: tb/tb_mux41_scan_ctrl.sv
// Scoreboard bench for mux41_scan_ctrl: expected per-cycle select/busy/done tuples are queued
// when a sweep is launched and popped against the DUT one cycle at a time.
module tb_mux41_scan_ctrl;

    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst, start, continuous, stop, y_in;
    logic [3:0]    ch_mask;
    logic [DW-1:0] dwell;
    logic          s0, s1, busy, done, sample_valid;
    logic [3:0]    sample;
    logic [3:0]    ymap;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [1:0] sel;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    // Behavioural 4:1 mux driven by the DUT's select lines.
    assign y_in = ymap[{s1, s0}];

    mux41_scan_ctrl #(.DWELL_W(DW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .continuous_i   (continuous),
        .stop_i         (stop),
        .ch_mask_i      (ch_mask),
        .dwell_i        (dwell),
        .y_in_i         (y_in),
        .s0_o           (s0),
        .s1_o           (s1),
        .busy_o         (busy),
        .done_o         (done),
        .sample_o       (sample),
        .sample_valid_o (sample_valid)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sweep(input logic [3:0] mask, input int dw, input logic first_done);
        logic fd;
        fd = first_done;
        for (int c = 0; c < 4; c++) begin
            if (mask[c]) begin
                for (int k = 0; k < dw; k++) begin
                    exp_q.push_back('{sel: 2'(c), busy: 1'b1, done: fd});
                    fd = 1'b0;
                end
            end
        end
    endtask

    task automatic push_idle(input logic d);
        exp_q.push_back('{sel: 2'd0, busy: 1'b0, done: d});
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; continuous = 1'b0; stop = 1'b0;
        ch_mask = 4'd0; dwell = '0; ymap = 4'd0;
        step(); step();
        rst = 1'b0;
        vectors++;
        if ({s1, s0, busy, done, sample, sample_valid} !== 9'b0) begin
            miscompares++;
            $display("FAIL reset: got sel=%b%b busy=%b done=%b sample=%b valid=%b, want all zero",
                     s1, s0, busy, done, sample, sample_valid);
        end
    endtask

    task automatic test_one_shot();
        exp_t e;
        ymap = 4'b0101; ch_mask = 4'b1111; dwell = 8'd3; continuous = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        push_sweep(4'b1111, 3, 1'b0);
        push_idle(1'b1);
        push_idle(1'b0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            vectors++;
            if ({s1, s0, busy, done} !== {e.sel, e.busy, e.done}) begin
                miscompares++;
                $display("FAIL one_shot cyc %0d: got sel=%b%b busy=%b done=%b, want sel=%b busy=%b done=%b",
                         i, s1, s0, busy, done, e.sel, e.busy, e.done);
            end
            step();
        end
        vectors++;
        if ({sample, sample_valid} !== {4'b0101, 1'b1}) begin
            miscompares++;
            $display("FAIL one_shot sample: got %b valid=%b, want 0101 valid=1", sample, sample_valid);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        ymap = 4'b1111; ch_mask = 4'b1111; dwell = 8'd3; continuous = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        vectors++;
        if ({s1, s0, busy, done, sample, sample_valid} !== 9'b0) begin
            miscompares++;
            $display("FAIL reset_mid: got sel=%b%b busy=%b done=%b sample=%b valid=%b, want all zero",
                     s1, s0, busy, done, sample, sample_valid);
        end
        repeat (5) push_idle(1'b0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            vectors++;
            if ({s1, s0, busy, done} !== {e.sel, e.busy, e.done}) begin
                miscompares++;
                $display("FAIL reset_mid idle cyc %0d: got sel=%b%b busy=%b done=%b, want sel=%b busy=%b done=%b",
                         i, s1, s0, busy, done, e.sel, e.busy, e.done);
            end
            step();
        end
    endtask

    task automatic test_dwell_zero();
        exp_t e;
        ymap = 4'b1111; ch_mask = 4'b1010; dwell = 8'd0; continuous = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        push_sweep(4'b1010, 1, 1'b0);
        push_idle(1'b1);
        push_idle(1'b0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            vectors++;
            if ({s1, s0, busy, done} !== {e.sel, e.busy, e.done}) begin
                miscompares++;
                $display("FAIL dwell_zero cyc %0d: got sel=%b%b busy=%b done=%b, want sel=%b busy=%b done=%b",
                         i, s1, s0, busy, done, e.sel, e.busy, e.done);
            end
            step();
        end
        vectors++;
        if ({sample, sample_valid} !== {4'b1010, 1'b1}) begin
            miscompares++;
            $display("FAIL dwell_zero sample: got %b valid=%b, want 1010 valid=1", sample, sample_valid);
        end
    endtask

    task automatic test_continuous_stop();
        exp_t e;
        ymap = 4'b0100; ch_mask = 4'b0110; dwell = 8'd2; continuous = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        continuous = 1'b0;  // latched at start, so this must not end scanning
        push_sweep(4'b0110, 2, 1'b0);
        push_sweep(4'b0110, 2, 1'b1);
        push_idle(1'b1);
        repeat (3) push_idle(1'b0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            vectors++;
            if ({s1, s0, busy, done} !== {e.sel, e.busy, e.done}) begin
                miscompares++;
                $display("FAIL cont_stop cyc %0d: got sel=%b%b busy=%b done=%b, want sel=%b busy=%b done=%b",
                         i, s1, s0, busy, done, e.sel, e.busy, e.done);
            end
            if (i == 5) stop = 1'b1;
            if (i == 6) stop = 1'b0;
            step();
        end
        vectors++;
        if (sample !== 4'b1100) begin
            miscompares++;
            $display("FAIL cont_stop sample: got %b, want 1100", sample);
        end
    endtask

    task automatic test_ignored_start();
        exp_t e;
        ch_mask = 4'b0000; dwell = 8'd2; continuous = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) push_idle(1'b0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            vectors++;
            if ({s1, s0, busy, done} !== {e.sel, e.busy, e.done}) begin
                miscompares++;
                $display("FAIL zero_mask cyc %0d: got sel=%b%b busy=%b done=%b, want sel=%b busy=%b done=%b",
                         i, s1, s0, busy, done, e.sel, e.busy, e.done);
            end
            step();
        end
        ymap = 4'b0010; ch_mask = 4'b0011; dwell = 8'd2; start = 1'b1;
        step();
        start = 1'b0;
        push_sweep(4'b0011, 2, 1'b0);
        push_idle(1'b1);
        push_idle(1'b0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            vectors++;
            if ({s1, s0, busy, done} !== {e.sel, e.busy, e.done}) begin
                miscompares++;
                $display("FAIL start_busy cyc %0d: got sel=%b%b busy=%b done=%b, want sel=%b busy=%b done=%b",
                         i, s1, s0, busy, done, e.sel, e.busy, e.done);
            end
            if (i == 1) begin
                start = 1'b1; ch_mask = 4'b1111; dwell = 8'd7;
            end
            if (i == 2) start = 1'b0;
            step();
        end
        vectors++;
        if (sample !== 4'b1110) begin
            miscompares++;
            $display("FAIL start_busy sample: got %b, want 1110", sample);
        end
    endtask

    task automatic test_mask_change();
        exp_t e;
        ymap = 4'b1001; ch_mask = 4'b1111; dwell = 8'd1; continuous = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        push_sweep(4'b1111, 1, 1'b0);
        push_sweep(4'b0001, 1, 1'b1);
        push_sweep(4'b0001, 1, 1'b1);
        push_idle(1'b1);
        push_idle(1'b0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            vectors++;
            if ({s1, s0, busy, done} !== {e.sel, e.busy, e.done}) begin
                miscompares++;
                $display("FAIL mask_change cyc %0d: got sel=%b%b busy=%b done=%b, want sel=%b busy=%b done=%b",
                         i, s1, s0, busy, done, e.sel, e.busy, e.done);
            end
            if (i == 1) ch_mask = 4'b0001;
            if (i == 5) stop = 1'b1;
            if (i == 6) stop = 1'b0;
            step();
        end
        continuous = 1'b0;
        vectors++;
        if ({sample, sample_valid} !== {4'b1001, 1'b1}) begin
            miscompares++;
            $display("FAIL mask_change sample: got %b valid=%b, want 1001 valid=1",
                     sample, sample_valid);
        end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_reset_mid();
        test_dwell_zero();
        test_continuous_stop();
        test_ignored_start();
        test_mask_change();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
